// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - elastic instruction queue between fetch and decode
//
// Holds {pc, inst, fetch exception flag, exception cause} entries in FIFO
// order. The oldest entry is presented to the decoder with a valid/ready
// handshake. flush discards all contents at the clock edge where it is high.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   flush               drop every entry; push/pop in the same cycle ignored
//   fetch_valid/ready   fetch-side handshake
//   fetch_pc/inst       entry pc and instruction word
//   fetch_is_exception  fetch-side exception attached to the entry
//   fetch_exc_cause     exception code for that entry
//   dec_valid/ready     decode-side handshake on the head entry
//   dec_pc/inst/...     head entry fields, zero when dec_valid=0
//   buf_count           occupancy 0..DEPTH
//
// Optional feature: define IBUF_BYPASS_EN for a zero-latency pass-through
// from fetch_* to dec_* when the queue is empty and the decoder is ready.
module inst_fetch_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [31:0]      fetch_pc,
  input  logic [31:0]      fetch_inst,
  input  logic             fetch_is_exception,
  input  logic [6:0]       fetch_exc_cause,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [31:0]      dec_pc,
  output logic [31:0]      dec_inst,
  output logic             dec_is_exception,
  output logic [6:0]       dec_exc_cause,
  output logic [PTR_W:0]   buf_count
);

  localparam int ENTRY_W = 72;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;

  logic               empty;
  logic               full;
  logic               bypass;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;

  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign fetch_ready = ~full & ~flush & ~rst;
  assign wr_entry    = {fetch_pc, fetch_inst, fetch_is_exception, fetch_exc_cause};
  assign head        = mem[rd_ptr];

`ifdef IBUF_BYPASS_EN
  // Empty queue with a ready decoder: hand the fetch entry straight through
  // and leave storage untouched.
  assign bypass = empty & fetch_valid & dec_ready & ~flush & ~rst;
`else
  assign bypass = 1'b0;
`endif

  // Internal queue operations; a bypassed entry is neither written nor popped.
  assign push = fetch_valid & fetch_ready & ~bypass;
  assign pop  = ~empty & dec_ready & ~flush;

  always_comb begin
    dec_valid        = 1'b0;
    dec_pc           = '0;
    dec_inst         = '0;
    dec_is_exception = 1'b0;
    dec_exc_cause    = '0;
    if (bypass) begin
      dec_valid        = 1'b1;
      dec_pc           = fetch_pc;
      dec_inst         = fetch_inst;
      dec_is_exception = fetch_is_exception;
      dec_exc_cause    = fetch_exc_cause;
    end else if (!empty) begin
      dec_valid        = 1'b1;
      dec_pc           = head[71:40];
      dec_inst         = head[39:8];
      dec_is_exception = head[7];
      dec_exc_cause    = head[6:0];
    end
  end

  // Storage needs no reset; push already excludes rst and flush.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

  assign buf_count = count;

endmodule
